alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//   8-bit combinational ALU for the CPU core datapath: pass, AND, rotate left/right,
//   add, subtract, increment, decrement on in0/in1 selected by a 4-bit opcode.
//   Result on `out` is combinational, valid in the same cycle as the operands.
//   A clocked status block registers the result and Z/N/C flags for the control unit.
// PARAMETERS
//   WIDTH  8  datapath width; all arithmetic is modulo 2**WIDTH
// PORTS
//   clk         in   1      system clock; all state updates on rising edge
//   reset       in   1      synchronous, active-high reset
//   in0         in   8      operand A; sole operand for pass, rotate, inc and dec
//   in1         in   8      operand B
//   select      in   4      opcode (table below)
//   num_rotate  in   2      rotate amount, 0..3 bit positions
//   out         out  8      combinational result
//   out_q       out  8      registered result
//   zero_q      out  1      registered: result == 0
//   neg_q       out  1      registered: result[7]
//   carry_q     out  1      registered carry/borrow (see below)
// BEHAVIOUR
//   Interface: one clock (clk); reset is synchronous and active-high.
//   Opcodes, out = f(in0, in1):
//     0  in0
//     1  in0 & in1
//     2  in0 rotated left by num_rotate
//     3  in0 rotated right by num_rotate
//     4  in0 + in1
//     5  in0 - in1
//     6  in0 + 1
//     7  in0 - 1
//     8..15  reserved; out = 8'h00
//   - `out` is purely combinational: no latency, it follows inputs within the same cycle.
//   - Rotates are circular: bits shifted out re-enter at the other end.
//     num_rotate = 0 returns in0 unchanged.
//   - Arithmetic wraps modulo 256: 255+1 = 0; 0-1 = 255.
//   - Carry, computed combinationally:
//     - ops 4, 6: 9th bit of the sum.
//     - ops 5, 7: borrow (1 when in0 < subtrahend).
//     - ops 0-3 and 8-15: 0.
//   - Each rising clk edge:
//     - reset = 1: out_q <= 0, zero_q <= 1, neg_q <= 0, carry_q <= 0.
//     - otherwise: out_q <= out, zero_q <= (out == 0), neg_q <= out[7], carry_q <= carry.
//     - Registered outputs lag `out` by exactly one cycle.
//   - Reset has no effect on the combinational `out`.
//   - Simultaneous input change and clock edge: the registers capture the value present
//     at the edge (standard setup timing).
//   - An unknown/X opcode must not infer latches; the default branch yields 0.
// STRUCTURE
//   - Shared package: opcode localparams
//     ALU_PASS=0, ALU_AND=1, ALU_ROL=2, ALU_ROR=3, ALU_ADD=4, ALU_SUB=5, ALU_INC=6, ALU_DEC=7.
//     The decoder uses the same constants.
//   - One sub-module: alu_rotator (in[7:0], amount[1:0], dir, out[7:0]), combinational barrel rotate.
//   - Rest: a single always @* case on select, plus one always @(posedge clk) for the
//     status registers.
// TESTING
//   1. in0=2, in1=1, num_rotate=0, sel 0/1/4/5/6/7 -> out = 2/0/3/1/3/1, checked 2 time units after each change.
//   2. in0=8'b10000001, num_rotate=2: sel=2 -> 8'b00000110; sel=3 -> 8'b01100000;
//      num_rotate=0 -> out=in0 for both.
//   3. Wrap: in0=255, sel=6 -> out=0, then after a clk edge zero_q=1, carry_q=1.
//      in0=0, sel=7 -> out=255, then neg_q=1, carry_q=1.
//   4. Sub borrow: in0=3, in1=5, sel=5 -> out=8'hFE, then after clk carry_q=1, neg_q=1, zero_q=0.
//   5. Reserved: sel=9..15 with any operands -> out=0.
//   6. Reset: drive sel=4, in0=in1=8'h80, assert reset over one edge ->
//      out_q=0, zero_q=1, carry_q=0 while out=0 combinationally.
//      Deassert -> next edge gives out_q=0, carry_q=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants and datapath width for the ALU and its decoder.
package alu_pkg;
  localparam int ALU_W = 8;

  localparam logic [3:0] ALU_PASS = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_ROL  = 4'd2;
  localparam logic [3:0] ALU_ROR  = 4'd3;
  localparam logic [3:0] ALU_ADD  = 4'd4;
  localparam logic [3:0] ALU_SUB  = 4'd5;
  localparam logic [3:0] ALU_INC  = 4'd6;
  localparam logic [3:0] ALU_DEC  = 4'd7;
endpackage

// File: rtl/alu_rotator.sv
// Combinational circular rotate of a W-bit word; dir=0 rotates left, dir=1 right.
module alu_rotator #(
  parameter int W = 8
) (
  input  logic [W-1:0] in,
  input  logic [1:0]   amount,
  input  logic         dir,
  output logic [W-1:0] out
);
  localparam int AW = $clog2(W);

  // Index arithmetic is modulo W because AW-bit sums wrap (W is a power of two).
  always_comb begin
    logic [AW-1:0] idx;
    out = '0;
    for (int i = 0; i < W; i++) begin
      idx    = dir ? AW'(i) + AW'(amount) : AW'(i) - AW'(amount);
      out[i] = in[idx];
    end
  end
endmodule

// File: rtl/alu.sv
// 8-bit combinational ALU with a registered result/flag status block.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [3:0]       select,
  input  logic [1:0]       num_rotate,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             zero_q,
  output logic             neg_q,
  output logic             carry_q
);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH-1:0] rot_out;
  logic [WIDTH-1:0] out_d;
  logic             carry_d;
  logic             zero_d;
  logic             neg_d;

  alu_rotator #(.W(WIDTH)) u_rot (
    .in     (in0),
    .amount (num_rotate),
    .dir    (select == ALU_ROR),
    .out    (rot_out)
  );

  // Arithmetic runs one bit wider so the top bit is carry on add, borrow on subtract.
  always_comb begin
    out_d   = '0;
    carry_d = 1'b0;
    case (select)
      ALU_PASS: out_d = in0;
      ALU_AND:  out_d = in0 & in1;
      ALU_ROL,
      ALU_ROR:  out_d = rot_out;
      ALU_ADD:  {carry_d, out_d} = {1'b0, in0} + {1'b0, in1};
      ALU_SUB:  {carry_d, out_d} = {1'b0, in0} - {1'b0, in1};
      ALU_INC:  {carry_d, out_d} = {1'b0, in0} + ONE;
      ALU_DEC:  {carry_d, out_d} = {1'b0, in0} - ONE;
      default: begin
        out_d   = '0;
        carry_d = 1'b0;
      end
    endcase
    zero_d = (out_d == '0);
    neg_d  = out_d[WIDTH-1];
  end

  assign out = out_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
    end
  end
endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed literal checks plus randomized ops against an arithmetic model.
module tb_alu;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in0 = '0, in1 = '0;
  logic [3:0] select = '0;
  logic [1:0] num_rotate = '0;
  logic [7:0] out, out_q;
  logic       zero_q, neg_q, carry_q;

  int n_cmp = 0;
  int n_bad = 0;

  alu dut (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .select(select),
    .num_rotate(num_rotate), .out(out), .out_q(out_q), .zero_q(zero_q),
    .neg_q(neg_q), .carry_q(carry_q)
  );

  always #5 clk = ~clk;

  // Reference: returns {carry, result} from plain integer arithmetic.
  function automatic logic [8:0] model(input int s, input int a, input int b, input int n);
    int r;
    int c;
    r = 0;
    c = 0;
    case (s)
      0: r = a;
      1: r = a & b;
      2: r = ((a << n) | (a >> (8 - n))) & 255;
      3: r = ((a >> n) | (a << (8 - n))) & 255;
      4: begin r = a + b; c = (r > 255) ? 1 : 0; r = r & 255; end
      5: begin c = (a < b) ? 1 : 0; r = (a - b) & 255; end
      6: begin r = a + 1; c = (r > 255) ? 1 : 0; r = r & 255; end
      7: begin c = (a < 1) ? 1 : 0; r = (a - 1) & 255; end
      default: r = 0;
    endcase
    return {c[0], r[7:0]};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected status captured at each rising edge from the inputs present then.
  logic [7:0] e_out_q;
  logic       e_zero, e_neg, e_carry;
  bit         e_vld = 1'b0;

  always @(posedge clk) begin
    logic [8:0] m;
    m = model(int'(select), int'(in0), int'(in1), int'(num_rotate));
    if (reset) begin
      e_out_q = 8'h00; e_zero = 1'b1; e_neg = 1'b0; e_carry = 1'b0;
    end else begin
      e_out_q = m[7:0]; e_zero = (m[7:0] == 8'h00); e_neg = m[7]; e_carry = m[8];
    end
    e_vld = 1'b1;
  end

  always @(negedge clk) begin
    chk("out_comb", {1'b0, out},
        {1'b0, model(int'(select), int'(in0), int'(in1), int'(num_rotate)) & 9'h0FF});
    if (e_vld) begin
      chk("out_q",   {1'b0, out_q},  {1'b0, e_out_q});
      chk("zero_q",  {8'h00, zero_q}, {8'h00, e_zero});
      chk("neg_q",   {8'h00, neg_q},  {8'h00, e_neg});
      chk("carry_q", {8'h00, carry_q}, {8'h00, e_carry});
    end
  end

  task automatic step(input int s, input int a, input int b, input int n, input bit r);
    @(posedge clk);
    #2;
    select = 4'(s); in0 = 8'(a); in1 = 8'(b); num_rotate = 2'(n); reset = r;
    #2;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sels[6];
    int exps[6];
    sels = '{0, 1, 4, 5, 6, 7};
    exps = '{2, 0, 3, 1, 3, 1};

    step(0, 0, 0, 0, 1'b1);
    after_edge();
    chk("rst_out_q", {1'b0, out_q}, 9'h000);
    chk("rst_zero_q", {8'h00, zero_q}, 9'h001);

    foreach (sels[i]) begin
      step(sels[i], 2, 1, 0, 1'b0);
      chk($sformatf("t1_sel%0d", sels[i]), {1'b0, out}, 9'(exps[i]));
    end

    step(2, 8'b1000_0001, 0, 2, 1'b0); chk("rol2", {1'b0, out}, 9'b0_0000_0110);
    step(3, 8'b1000_0001, 0, 2, 1'b0); chk("ror2", {1'b0, out}, 9'b0_0110_0000);
    step(2, 8'b1000_0001, 0, 0, 1'b0); chk("rol0", {1'b0, out}, 9'b0_1000_0001);
    step(3, 8'b1000_0001, 0, 0, 1'b0); chk("ror0", {1'b0, out}, 9'b0_1000_0001);

    step(6, 255, 0, 0, 1'b0); chk("inc_wrap", {1'b0, out}, 9'h000);
    after_edge();
    chk("inc_zero_q", {8'h00, zero_q}, 9'h001);
    chk("inc_carry_q", {8'h00, carry_q}, 9'h001);
    step(7, 0, 0, 0, 1'b0); chk("dec_wrap", {1'b0, out}, 9'h0FF);
    after_edge();
    chk("dec_neg_q", {8'h00, neg_q}, 9'h001);
    chk("dec_carry_q", {8'h00, carry_q}, 9'h001);

    step(5, 3, 5, 0, 1'b0); chk("sub_borrow", {1'b0, out}, 9'h0FE);
    after_edge();
    chk("sub_carry_q", {8'h00, carry_q}, 9'h001);
    chk("sub_neg_q", {8'h00, neg_q}, 9'h001);
    chk("sub_zero_q", {8'h00, zero_q}, 9'h000);

    for (int s = 9; s < 16; s++) begin
      step(s, int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(3)), 1'b0);
      chk($sformatf("rsvd_%0d", s), {1'b0, out}, 9'h000);
    end

    step(4, 8'h80, 8'h80, 0, 1'b1);
    after_edge();
    chk("rst_hold_out_q", {1'b0, out_q}, 9'h000);
    chk("rst_hold_zero_q", {8'h00, zero_q}, 9'h001);
    chk("rst_hold_carry_q", {8'h00, carry_q}, 9'h000);
    chk("rst_hold_out", {1'b0, out}, 9'h000);
    step(4, 8'h80, 8'h80, 0, 1'b0);
    after_edge();
    chk("rel_out_q", {1'b0, out_q}, 9'h000);
    chk("rel_carry_q", {8'h00, carry_q}, 9'h001);

    for (int k = 0; k < 400; k++)
      step(int'($urandom_range(15)), int'($urandom_range(255)), int'($urandom_range(255)),
           int'($urandom_range(3)), ($urandom_range(19) == 0));

    after_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
